// File: rtl/reg_bus_pkg.sv
// Shared types and limits for the register bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_bus_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 32;
    localparam int MAX_READ_LAT = 4;
    localparam int LAT_CNT_W    = $clog2(MAX_READ_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/reg_bus_arbiter_rr_pick.sv
// Round-robin picker: first set req bit after last_grant, wrapping.
// Latency: combinational.
// Backpressure: none; valid is low when no request is pending.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin register bus arbiter, one transaction in flight; optional REG_BUS_ARB_LOCK_EN adds req_lock.
// Latency: request seen in IDLE at cycle 0 is acked in cycle 2+READ_LAT; one txn per 3+READ_LAT cycles.
// Backpressure: requesters hold req and fields until their one-cycle ack; no other stall.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef REG_BUS_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_wdata,
    output logic                      bus_wr,
    output logic                      bus_rd,
    input  logic [DATA_W-1:0]         bus_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t             state, state_nxt;
    logic [IDX_W-1:0]       grant, last_grant;
    logic [IDX_W-1:0]       pick_idx, sel_idx;
    logic                   pick_vld, sel_vld, lock_hit;
    logic                   lat_wr;
    logic [ADDR_W-1:0]      lat_addr;
    logic [DATA_W-1:0]      lat_wdata, rdata_q;
    logic [LAT_CNT_W-1:0]   lat_cnt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant),
        .valid      (pick_vld),
        .index      (pick_idx)
    );

`ifdef REG_BUS_ARB_LOCK_EN
    logic lock_flag;

    // The lock only survives one IDLE cycle: taken if the owner still requests, dropped otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_flag <= 1'b0;
        end else if (state == DONE) begin
            lock_flag <= req_lock[grant];
        end else if (state == IDLE) begin
            lock_flag <= 1'b0;
        end
    end

    assign lock_hit = lock_flag && req[last_grant];
`else
    assign lock_hit = 1'b0;
`endif

    assign sel_vld = lock_hit || pick_vld;
    assign sel_idx = lock_hit ? last_grant : pick_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (lat_cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            lat_wr     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_cnt    <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        grant     <= sel_idx;
                        lat_wr    <= req_wr[sel_idx];
                        lat_addr  <= req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
                        lat_wdata <= req_wdata[int'(sel_idx)*DATA_W +: DATA_W];
                    end
                end
                ISSUE: lat_cnt <= LAT_CNT_W'(READ_LAT - 1);
                WAIT: begin
                    // Writes also land here: the capture is the post-write read-back.
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LAT_CNT_W'(1);
                    end else begin
                        rdata_q <= bus_rdata;
                    end
                end
                DONE: last_grant <= grant;
                default: ;
            endcase
        end
    end

    // Strobes decode from state so reset cancels them without waiting for a clock.
    assign bus_addr  = lat_addr;
    assign bus_wdata = lat_wdata;
    assign bus_wr    = (state == ISSUE) && lat_wr;
    assign bus_rd    = (state == ISSUE) && !lat_wr;
    assign rdata     = rdata_q;

    always_comb begin
        ack = '0;
        if (state == DONE) ack[grant] = 1'b1;
    end

    a_strobe_excl: assert property (@(posedge clk) disable iff (reset) !(bus_wr && bus_rd));
    a_ack_onehot:  assert property (@(posedge clk) disable iff (reset) $onehot0(ack));

endmodule
